// File: rtl/instr_fetch.sv
// instr_fetch: bytecode fetch unit for a stack-machine core.
//   Reads an opcode from synchronous program memory (1-cycle read latency),
//   presents it to the external opcode decoder, and fetches the 0/1/2
//   argument bytes that the decoder's argc asks for. The complete
//   instruction is then held until execute acks it. Branch targets follow
//   the JVM rule: opcode address + signed 16-bit {arg0,arg1}.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   start, start_pc           begin fetching at start_pc (honoured in IDLE only)
//   pmem_addr, pmem_rdata     program memory address (= pc) / data from last cycle
//   argc                      decoder argument count for the current opcode
//   opcode, arg0, arg1        latched instruction bytes
//   instr_pc                  address of the latched opcode
//   instr_valid               instruction complete and stable
//   instr_ack                 execute accepts the instruction
//   branch_taken, halt        qualify instr_ack (halt has priority)
//   busy                      high in every state except IDLE
module instr_fetch #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_pc,
  output logic [ADDR_W-1:0] pmem_addr,
  input  logic [7:0]        pmem_rdata,
  input  logic [1:0]        argc,
  output logic [7:0]        opcode,
  output logic [7:0]        arg0,
  output logic [7:0]        arg1,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ack,
  input  logic              branch_taken,
  input  logic              halt,
  output logic              busy
);

  typedef enum logic [2:0] {
    IDLE, OP_RD, OP_LAT, DEC, A1_LAT, A2_RD, A2_LAT, VALID
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] ipc_q, ipc_d;
  logic [7:0]        op_q, op_d;
  logic [7:0]        a0_q, a0_d;
  logic [7:0]        a1_q, a1_d;
  logic              vld_q, vld_d;
  logic [ADDR_W-1:0] br_tgt;
  logic signed [15:0] br_off;

  // Signed size cast sign-extends (or truncates) the 16-bit offset to ADDR_W,
  // so the add wraps modulo 2^ADDR_W for any address width.
  assign br_off = $signed({a0_q, a1_q});
  assign br_tgt = ipc_q + ADDR_W'(br_off);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ipc_d   = ipc_q;
    op_d    = op_q;
    a0_d    = a0_q;
    a1_d    = a1_q;
    vld_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          pc_d    = start_pc;
          state_d = OP_RD;
        end
      end
      OP_RD:  state_d = OP_LAT;
      OP_LAT: begin
        op_d    = pmem_rdata;
        ipc_d   = pc_q;
        a0_d    = 8'h00;
        a1_d    = 8'h00;
        pc_d    = pc_q + ADDR_W'(1);
        state_d = DEC;
      end
      DEC: begin
        // pc already points at the first arg byte, so its read is in flight now
        if (argc == 2'd0) begin
          state_d = VALID;
          vld_d   = 1'b1;
        end else begin
          state_d = A1_LAT;
        end
      end
      A1_LAT: begin
        a0_d = pmem_rdata;
        pc_d = pc_q + ADDR_W'(1);
        if (argc == 2'd1) begin
          state_d = VALID;
          vld_d   = 1'b1;
        end else begin
          state_d = A2_RD;   // argc 2 and 3 both fetch two bytes
        end
      end
      A2_RD:  state_d = A2_LAT;
      A2_LAT: begin
        a1_d    = pmem_rdata;
        pc_d    = pc_q + ADDR_W'(1);
        state_d = VALID;
        vld_d   = 1'b1;
      end
      VALID: begin
        vld_d = 1'b1;
        if (instr_ack) begin
          vld_d = 1'b0;
          if (halt) begin
            state_d = IDLE;
          end else if (branch_taken) begin
            pc_d    = br_tgt;
            state_d = OP_RD;
          end else begin
            state_d = OP_RD;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= '0;
      ipc_q   <= '0;
      op_q    <= 8'h00;
      a0_q    <= 8'h00;
      a1_q    <= 8'h00;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ipc_q   <= ipc_d;
      op_q    <= op_d;
      a0_q    <= a0_d;
      a1_q    <= a1_d;
      vld_q   <= vld_d;
    end
  end

  assign pmem_addr   = pc_q;
  assign opcode      = op_q;
  assign arg0        = a0_q;
  assign arg1        = a1_q;
  assign instr_pc    = ipc_q;
  assign instr_valid = vld_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;
  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  // 16-bit instance
  logic        start, ack, br, hlt;
  logic [15:0] start_pc, pmem_addr, instr_pc;
  logic [7:0]  rdata, opcode, arg0, arg1;
  logic [1:0]  argc;
  logic        valid, busy;
  logic [7:0]  mem [0:65535];

  // 8-bit instance (wrap test)
  logic        s8_start, s8_ack;
  logic [7:0]  s8_start_pc, s8_addr, s8_ipc;
  logic [7:0]  s8_rdata, s8_op, s8_a0, s8_a1;
  logic [1:0]  s8_argc;
  logic        s8_valid, s8_busy;
  logic [7:0]  mem8 [0:255];

  instr_fetch #(.ADDR_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .start_pc(start_pc),
    .pmem_addr(pmem_addr), .pmem_rdata(rdata), .argc(argc),
    .opcode(opcode), .arg0(arg0), .arg1(arg1), .instr_pc(instr_pc),
    .instr_valid(valid), .instr_ack(ack), .branch_taken(br), .halt(hlt),
    .busy(busy)
  );

  instr_fetch #(.ADDR_W(8)) dut8 (
    .clk(clk), .rst(rst), .start(s8_start), .start_pc(s8_start_pc),
    .pmem_addr(s8_addr), .pmem_rdata(s8_rdata), .argc(s8_argc),
    .opcode(s8_op), .arg0(s8_a0), .arg1(s8_a1), .instr_pc(s8_ipc),
    .instr_valid(s8_valid), .instr_ack(s8_ack), .branch_taken(1'b0), .halt(1'b0),
    .busy(s8_busy)
  );

  // synchronous program memories, 1-cycle read latency
  always @(posedge clk) rdata    <= mem[pmem_addr];
  always @(posedge clk) s8_rdata <= mem8[s8_addr];

  // minimal decoder: BIPUSH=1 arg, SIPUSH/GOTO=2 args, everything else 0
  function automatic logic [1:0] dec_argc(input logic [7:0] op);
    case (op)
      8'h10:        return 2'd1;
      8'h11, 8'hA7: return 2'd2;
      default:      return 2'd0;
    endcase
  endfunction
  assign argc    = dec_argc(opcode);
  assign s8_argc = dec_argc(s8_op);

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; tick; rst = 1'b0;
  endtask

  // pulse start; on return the DUT is in its OP_RD cycle (t)
  task automatic go(input logic [15:0] pc);
    start_pc = pc; start = 1'b1; tick; start = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!valid && n < 20) begin tick; n++; end
  endtask

  task automatic wait_valid8(output int n);
    n = 0;
    while (!s8_valid && n < 20) begin tick; n++; end
  endtask

  int lat;
  logic [63:0] snap_exp;

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    for (int i = 0; i < 256; i++) mem8[i] = 8'h00;
    rst = 1'b1; start = 0; start_pc = 0; ack = 0; br = 0; hlt = 0;
    s8_start = 0; s8_start_pc = 0; s8_ack = 0;
    tick; tick; rst = 1'b0;

    // reset state
    chk("rst_addr",  pmem_addr, 16'h0000);
    chk("rst_op",    opcode,    8'h00);
    chk("rst_args",  {arg0, arg1}, 16'h0000);
    chk("rst_ipc",   instr_pc,  16'h0000);
    chk("rst_vb",    {valid, busy}, 2'b00);

    // 1: IADD at 0x10, argc 0
    mem[16'h0010] = 8'h60; mem[16'h0011] = 8'h00;
    go(16'h0010);
    chk("t1_busy", busy, 1'b1);
    wait_valid(lat);
    chk("t1_lat",  lat, 3);
    chk("t1_op",   opcode, 8'h60);
    chk("t1_ipc",  instr_pc, 16'h0010);
    ack = 1; tick; ack = 0;
    chk("t1_next", pmem_addr, 16'h0011);
    chk("t1_vdrop", valid, 1'b0);
    do_reset;

    // 2: SIPUSH 0x1234 at 0x20
    mem[16'h0020] = 8'h11; mem[16'h0021] = 8'h12; mem[16'h0022] = 8'h34;
    go(16'h0020);
    wait_valid(lat);
    chk("t2_lat",  lat, 6);
    chk("t2_args", {arg0, arg1}, 16'h1234);
    ack = 1; tick; ack = 0;
    chk("t2_next", pmem_addr, 16'h0023);
    do_reset;

    // 3: GOTO -4 and GOTO +16 from 0x100
    mem[16'h0100] = 8'hA7; mem[16'h0101] = 8'hFF; mem[16'h0102] = 8'hFC;
    go(16'h0100);
    wait_valid(lat);
    chk("t3_lat", lat, 6);
    ack = 1; br = 1; tick; ack = 0; br = 0;
    chk("t3_back", pmem_addr, 16'h00FC);
    do_reset;
    mem[16'h0101] = 8'h00; mem[16'h0102] = 8'h10;
    go(16'h0100);
    wait_valid(lat);
    ack = 1; br = 1; tick; ack = 0; br = 0;
    chk("t3_fwd", pmem_addr, 16'h0110);
    do_reset;

    // 4: ADDR_W=8, BIPUSH at 0xFE, arg at 0xFF, next opcode wraps to 0x00
    mem8[8'hFE] = 8'h10; mem8[8'hFF] = 8'h05; mem8[8'h00] = 8'h60;
    s8_start_pc = 8'hFE; s8_start = 1; tick; s8_start = 0;
    wait_valid8(lat);
    chk("t4_lat",  lat, 4);
    chk("t4_arg",  {s8_op, s8_a0, s8_a1}, 24'h100500);
    s8_ack = 1; tick; s8_ack = 0;
    chk("t4_wrap", s8_addr, 8'h00);
    wait_valid8(lat);
    chk("t4_op2",  {s8_op, s8_ipc}, 16'h6000);
    s8_ack = 1; tick; s8_ack = 0;

    // 5: hold in VALID, then halt beats branch
    mem[16'h0030] = 8'h10; mem[16'h0031] = 8'h7F;
    go(16'h0030);
    wait_valid(lat);
    chk("t5_lat", lat, 4);
    // {opcode, arg0, arg1, instr_pc, pmem_addr, valid, busy}
    snap_exp = {6'b0, 8'h10, 8'h7F, 8'h00, 16'h0030, 16'h0032, 1'b1, 1'b1};
    for (int i = 0; i < 10; i++) begin
      br = i[0]; hlt = i[1];   // without ack these must be ignored
      tick;
      chk("t5_hold", {6'b0, opcode, arg0, arg1, instr_pc, pmem_addr, valid, busy}, snap_exp);
    end
    ack = 1; hlt = 1; br = 1; tick; ack = 0; hlt = 0; br = 0;
    chk("t5_halt", {busy, valid, pmem_addr}, {2'b00, 16'h0032});
    chk("t5_opkeep", opcode, 8'h10);
    tick;
    chk("t5_idle", {busy, pmem_addr}, {1'b0, 16'h0032});
    mem[16'h0040] = 8'h60; mem[16'h0090] = 8'h11;
    go(16'h0040);
    start_pc = 16'h0090; start = 1; tick; start = 0;   // ignored while busy
    wait_valid(lat);
    chk("t5_nostart", {opcode, instr_pc}, {8'h60, 16'h0040});
    ack = 1; hlt = 1; tick; ack = 0; hlt = 0;

    // 6: reset during A1_LAT of SIPUSH
    go(16'h0020);
    tick; tick; tick;   // OP_LAT, DEC, A1_LAT
    chk("t6_mid", {valid, busy}, 2'b01);
    do_reset;
    chk("t6_rst", {opcode, arg0, arg1, valid, busy}, {24'h000000, 2'b00});
    chk("t6_pc",  {instr_pc, pmem_addr}, 32'h0);
    go(16'h0020);
    wait_valid(lat);
    chk("t6_lat", lat, 6);
    chk("t6_ins", {opcode, arg0, arg1, instr_pc}, {8'h11, 8'h12, 8'h34, 16'h0020});

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
